mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, synchronous-read unified memory between the instruction-fetch port and the load/store port of the core. Arbitration is per cycle with a fixed data-first priority and a starvation guard for fetch. Read data is routed back to the owning requester one cycle later. It sits between the core's fetch/memory stages and the unified memory macro, and replaces separate instruction and data memories.

## Interface
- ADDR_WIDTH, 32, byte address width of all ports
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch is waiting; range 1..15

- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- if_req_i  input  1  fetch request; read only
- if_addr_i  input  ADDR_WIDTH  fetch byte address, word aligned
- if_gnt_o  output  1  fetch request accepted this cycle
- if_rvalid_o  output  1  fetch response valid
- if_rdata_o  output  DATA_WIDTH  fetch read data
- d_req_i  input  1  data request
- d_we_i  input  1  1 = store, 0 = load
- d_be_i  input  DATA_WIDTH/8  store byte enables, already lane-aligned
- d_addr_i  input  ADDR_WIDTH  data byte address
- d_wdata_i  input  DATA_WIDTH  store data, already lane-aligned
- d_gnt_o  output  1  data request accepted this cycle
- d_rvalid_o  output  1  data response valid; asserted for loads and stores
- d_rdata_o  output  DATA_WIDTH  load data; 0 on store responses
- mem_req_o  output  1  memory access this cycle
- mem_we_o  output  1  memory write
- mem_be_o  output  DATA_WIDTH/8  memory byte enables
- mem_addr_o  output  ADDR_WIDTH  memory byte address
- mem_wdata_o  output  DATA_WIDTH  memory write data
- mem_rdata_i  input  DATA_WIDTH  memory read data, valid the cycle after an accepted read

## Operation
- Handshake: a request is accepted in the cycle where req and gnt are both high. gnt is combinational from the req inputs and the registered arbiter state.
- A requester holds req, addr, we, be and wdata stable until gnt is high.
- Back-to-back requests are allowed: one accepted request per cycle, fully pipelined.
- At most one gnt is high per cycle. The memory always accepts, so mem_req_o = if_gnt_o | d_gnt_o.
- Priority:
  - Data wins by default.
  - Fetch wins when if_req_i is high and streak == MAX_D_STREAK.
  - A single requester always wins.
- Streak counter, 4 bits:
  - increments on a data grant while if_req_i is high;
  - saturates at MAX_D_STREAK;
  - clears on a fetch grant or whenever if_req_i is low.
- Mux: mem_* carry the granted port's fields. Fetch grants drive we=0 and be=all-ones. With no grant, mem_we_o=0, mem_be_o=0, and addr/wdata are 0.
- Response tracking: register resp_owner (NONE/IF/D) and resp_we, loaded from the grant each cycle.
  - Next cycle, the owner's rvalid is 1.
  - IF owner: rdata = mem_rdata_i.
  - D owner: d_rdata_o = mem_rdata_i for loads, 0 for stores.
  - Non-owner rdata is 0.
- A store with be=0 is still granted and acknowledged; memory contents are unchanged.

## Timing
- Reset: every output is 0, streak = 0, resp_owner = NONE.
- Reset asserted mid-operation: a response in flight is dropped. rvalid is 0 in the cycle after the reset edge. Requests presented during reset are not granted.
- Latency: request accepted in cycle N gives rvalid and rdata in cycle N+1. The store write takes effect at the edge ending cycle N.
- Simultaneous requests in cycle N: one gnt in N. The loser's gnt stays 0 and it keeps req high.
- Requester releases req in the same cycle it is granted: no spurious grant. Grants are not registered.
- Fetch waiting for K cycles under continuous data requests is granted at the latest in cycle MAX_D_STREAK.

## Structure
- Shared package additions:
  - typedef enum logic [1:0] mem_owner_e {OWN_NONE, OWN_IF, OWN_D};
  - localparam MEM_BE_ALL = 4'hF.
- Single flat module; no natural sub-module.
- The core's load-alignment and store-alignment logic stays outside the block.

## Test plan
- Fetch only: if_req=1 at addr 0x0, 0x4, 0x8 on consecutive cycles, with memory preloaded 0x00500093, 0x00100113, 0x002081B3 -> if_gnt=1 each cycle; if_rvalid=1 in cycles 1..3 with those words in order.
- Collision: if_req and d_req (load 0x100 = 0xDEADBEEF) in the same cycle -> d_gnt=1, if_gnt=0. Next cycle: d_rvalid=1 with 0xDEADBEEF, if_gnt=1.
- Starvation: d_req held continuously for 10 cycles with if_req=1, MAX_D_STREAK=4 -> d_gnt in cycles 0–3, if_gnt in cycle 4, d_gnt resumes in cycle 5, if_gnt again in cycle 9.
- Store: store be=4'b0100, wdata=0x00AB0000 to 0x200 holding 0x11223344 -> d_rvalid=1 with d_rdata=0 next cycle; a later load returns 0x11AB3344.
- Reset mid-flight: load granted in cycle N, rst=1 in cycle N -> d_rvalid=0 in cycle N+1; streak=0; all outputs 0 while rst is held.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Records which requester owns the response that returns on the next cycle.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } mem_owner_e;

  // Byte-enable value used for full-word accesses on a 32-bit memory.
  localparam logic [3:0] MEM_BE_ALL = 4'hF;

  localparam int STREAK_W = 4;

  // Observable arbiter state, grouped so a checker can bind to one signal.
  typedef struct packed {
    logic [STREAK_W-1:0] streak;
    mem_owner_e          resp_owner;
    logic                resp_we;
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Per-cycle arbiter between the fetch and load/store ports of one synchronous-read
// memory: data-first priority, with a bounded data streak so fetch cannot starve.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  import mem_port_arbiter_pkg::*;

  localparam int BE_W = DATA_WIDTH / 8;

  // Handshake: a request is accepted in the cycle where req and gnt are both high.
  // gnt is combinational from req and registered state; requesters hold their fields
  // stable until granted. Responses arrive exactly one cycle after acceptance.

  logic [STREAK_W-1:0] streak;
  mem_owner_e          resp_owner;
  logic                resp_we;
  arb_state_t          dbg_state;

  logic streak_full;
  logic if_wins;

  assign dbg_state   = '{streak: streak, resp_owner: resp_owner, resp_we: resp_we};
  assign streak_full = (streak == STREAK_W'(MAX_D_STREAK));
  assign if_wins     = if_req_i && (!d_req_i || streak_full);

  // Everything is forced quiet while reset is held, including in-flight responses.
  assign if_gnt_o  = !rst && if_wins;
  assign d_gnt_o   = !rst && d_req_i && !if_wins;
  assign mem_req_o = if_gnt_o | d_gnt_o;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (d_gnt_o) begin
      mem_we_o    = d_we_i;
      mem_be_o    = d_be_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (if_gnt_o) begin
      mem_be_o    = {BE_W{1'b1}};
      mem_addr_o  = if_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak     <= '0;
      resp_owner <= OWN_NONE;
      resp_we    <= 1'b0;
    end else begin
      resp_we <= d_gnt_o && d_we_i;
      if (d_gnt_o)       resp_owner <= OWN_D;
      else if (if_gnt_o) resp_owner <= OWN_IF;
      else               resp_owner <= OWN_NONE;

      // The streak only measures how long fetch has been kept waiting.
      if (!if_req_i || if_gnt_o)         streak <= '0;
      else if (d_gnt_o && !streak_full)  streak <= streak + 1'b1;
    end
  end

  assign if_rvalid_o = !rst && (resp_owner == OWN_IF);
  assign d_rvalid_o  = !rst && (resp_owner == OWN_D);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o   = (d_rvalid_o && !resp_we) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous-read memory.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o;
  logic          if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i;
  logic          d_we_i;
  logic [3:0]    d_be_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic          d_gnt_o;
  logic          d_rvalid_o;
  logic [DW-1:0] d_rdata_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] mem [256];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // Memory model: returns the old word on every access, including writes,
  // so store responses see non-zero read data that the arbiter must suppress.
  always @(posedge clk) begin
    if (mem_req_o) begin
      mem_rdata_i <= mem[mem_addr_o[9:2]];
      if (mem_we_o)
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem[mem_addr_o[9:2]][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_i  = 1'b0;
    if_addr_i = '0;
    d_req_i   = 1'b0;
    d_we_i    = 1'b0;
    d_be_i    = '0;
    d_addr_i  = '0;
    d_wdata_i = '0;
  endtask

  task automatic drive_load(input logic [AW-1:0] addr);
    d_req_i  = 1'b1;
    d_we_i   = 1'b0;
    d_be_i   = 4'hF;
    d_addr_i = addr;
  endtask

  task automatic drive_store(input logic [AW-1:0] addr, input logic [3:0] be,
                             input logic [DW-1:0] wdata);
    d_req_i   = 1'b1;
    d_we_i    = 1'b1;
    d_be_i    = be;
    d_addr_i  = addr;
    d_wdata_i = wdata;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    if_req_i  = 1'b1;
    if_addr_i = 32'h40;
    drive_store(32'h80, 4'hF, 32'hCAFEF00D);
    step();
    step();
    @(negedge clk);
    checks++;
    if ({if_gnt_o, d_gnt_o, mem_req_o, mem_we_o} !== 4'b0000)
      $display("FAIL reset_gnt: got gnt/req/we %b required 0000", {if_gnt_o, d_gnt_o, mem_req_o, mem_we_o});
    else passes++;
    checks++;
    if ({mem_be_o, mem_addr_o, mem_wdata_o} !== '0)
      $display("FAIL reset_mem_fields: got be %h addr %h wdata %h required 0", mem_be_o, mem_addr_o, mem_wdata_o);
    else passes++;
    checks++;
    if ({if_rvalid_o, d_rvalid_o, if_rdata_o, d_rdata_o} !== '0)
      $display("FAIL reset_resp: got if_rv %b d_rv %b if_rd %h d_rd %h required 0", if_rvalid_o, d_rvalid_o, if_rdata_o, d_rdata_o);
    else passes++;
    checks++;
    if (dut.dbg_state !== '{streak: 4'd0, resp_owner: OWN_NONE, resp_we: 1'b0})
      $display("FAIL reset_state: got %h required 0", dut.dbg_state);
    else passes++;
    step();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({mem_req_o, mem_be_o, mem_addr_o, if_rvalid_o, d_rvalid_o} !== '0)
      $display("FAIL idle_outputs: got req %b be %h addr %h rv %b%b required 0", mem_req_o, mem_be_o, mem_addr_o, if_rvalid_o, d_rvalid_o);
    else passes++;
  endtask

  task automatic test_fetch_only();
    logic [DW-1:0] exp_words [3];
    exp_words = '{32'h00500093, 32'h00100113, 32'h002081B3};
    for (int c = 0; c < 4; c++) begin
      step();
      if_req_i  = (c < 3);
      if_addr_i = (c < 3) ? 32'(c * 4) : '0;
      @(negedge clk);
      checks++;
      if (if_gnt_o !== (c < 3) || d_gnt_o !== 1'b0)
        $display("FAIL fetch_gnt c%0d: got if_gnt %b d_gnt %b required %b 0", c, if_gnt_o, d_gnt_o, c < 3);
      else passes++;
      if (c < 3) begin
        checks++;
        if (mem_be_o !== MEM_BE_ALL || mem_we_o !== 1'b0 || mem_addr_o !== 32'(c * 4))
          $display("FAIL fetch_mux c%0d: got be %h we %b addr %h required f 0 %h", c, mem_be_o, mem_we_o, mem_addr_o, c * 4);
        else passes++;
      end
      if (c > 0) begin
        checks++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== exp_words[c-1] || d_rvalid_o !== 1'b0)
          $display("FAIL fetch_resp c%0d: got rv %b rdata %h required 1 %h", c, if_rvalid_o, if_rdata_o, exp_words[c-1]);
        else passes++;
      end
    end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (if_rvalid_o !== 1'b0 || if_rdata_o !== '0)
      $display("FAIL fetch_drain: got rv %b rdata %h required 0 0", if_rvalid_o, if_rdata_o);
    else passes++;
  endtask

  task automatic test_collision();
    step();
    if_req_i  = 1'b1;
    if_addr_i = 32'h0;
    drive_load(32'h100);
    @(negedge clk);
    checks++;
    if (d_gnt_o !== 1'b1 || if_gnt_o !== 1'b0 || mem_addr_o !== 32'h100)
      $display("FAIL collide_gnt: got d %b if %b addr %h required 1 0 100", d_gnt_o, if_gnt_o, mem_addr_o);
    else passes++;
    step();
    d_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if (if_gnt_o !== 1'b1 || d_rvalid_o !== 1'b1 || d_rdata_o !== 32'hDEADBEEF || if_rvalid_o !== 1'b0)
      $display("FAIL collide_resp: got if_gnt %b d_rv %b d_rd %h if_rv %b required 1 1 deadbeef 0", if_gnt_o, d_rvalid_o, d_rdata_o, if_rvalid_o);
    else passes++;
    checks++;
    if (if_rdata_o !== '0)
      $display("FAIL collide_nonowner: got if_rdata %h required 0", if_rdata_o);
    else passes++;
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h00500093 || d_rvalid_o !== 1'b0 || d_rdata_o !== '0)
      $display("FAIL collide_fetch_resp: got if_rv %b if_rd %h d_rv %b d_rd %h required 1 00500093 0 0", if_rvalid_o, if_rdata_o, d_rvalid_o, d_rdata_o);
    else passes++;
    checks++;
    if (mem_req_o !== 1'b0)
      $display("FAIL release_no_spurious: got mem_req %b required 0", mem_req_o);
    else passes++;
  endtask

  task automatic test_starvation();
    logic exp_if;
    step();
    if_req_i  = 1'b1;
    if_addr_i = 32'h4;
    drive_load(32'h100);
    for (int c = 0; c < 10; c++) begin
      exp_if = (c == 4) || (c == 9);
      @(negedge clk);
      checks++;
      if (if_gnt_o !== exp_if || d_gnt_o !== !exp_if)
        $display("FAIL starve c%0d: got if_gnt %b d_gnt %b required %b %b", c, if_gnt_o, d_gnt_o, exp_if, !exp_if);
      else passes++;
      if (c == 5) begin
        checks++;
        if (if_rvalid_o !== 1'b1 || if_rdata_o !== 32'h00100113)
          $display("FAIL starve_fetch_resp: got rv %b rdata %h required 1 00100113", if_rvalid_o, if_rdata_o);
        else passes++;
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_store();
    drive_store(32'h200, 4'b0100, 32'h00AB0000);
    @(negedge clk);
    checks++;
    if (d_gnt_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== 4'b0100 || mem_wdata_o !== 32'h00AB0000)
      $display("FAIL store_mux: got gnt %b we %b be %b wdata %h required 1 1 0100 00ab0000", d_gnt_o, mem_we_o, mem_be_o, mem_wdata_o);
    else passes++;
    step();
    drive_store(32'h200, 4'b0000, 32'hFFFFFFFF);
    @(negedge clk);
    checks++;
    if (d_rvalid_o !== 1'b1 || d_rdata_o !== '0)
      $display("FAIL store_resp: got rv %b rdata %h required 1 0", d_rvalid_o, d_rdata_o);
    else passes++;
    checks++;
    if (d_gnt_o !== 1'b1 || mem_be_o !== 4'b0000)
      $display("FAIL store_be0_gnt: got gnt %b be %b required 1 0000", d_gnt_o, mem_be_o);
    else passes++;
    step();
    drive_load(32'h200);
    @(negedge clk);
    checks++;
    if (d_rvalid_o !== 1'b1 || d_rdata_o !== '0 || d_gnt_o !== 1'b1)
      $display("FAIL store_be0_resp: got rv %b rdata %h gnt %b required 1 0 1", d_rvalid_o, d_rdata_o, d_gnt_o);
    else passes++;
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (d_rvalid_o !== 1'b1 || d_rdata_o !== 32'h11AB3344)
      $display("FAIL store_readback: got rv %b rdata %h required 1 11ab3344", d_rvalid_o, d_rdata_o);
    else passes++;
    step();
  endtask

  task automatic test_reset_mid_flight();
    if_req_i  = 1'b1;
    if_addr_i = 32'h8;
    drive_load(32'h100);
    @(negedge clk);
    step();
    @(negedge clk);
    checks++;
    if (d_gnt_o !== 1'b1 || dut.streak !== 4'd1)
      $display("FAIL midrst_pre: got gnt %b streak %0d required 1 1", d_gnt_o, dut.streak);
    else passes++;
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_rvalid_o, d_rdata_o, d_gnt_o, if_gnt_o, mem_req_o} !== '0)
      $display("FAIL midrst_drop: got rv %b rdata %h gnt %b%b req %b required 0", d_rvalid_o, d_rdata_o, d_gnt_o, if_gnt_o, mem_req_o);
    else passes++;
    step();
    @(negedge clk);
    checks++;
    if ({mem_req_o, mem_be_o, mem_addr_o, d_rvalid_o, if_rvalid_o} !== '0 || dut.streak !== 4'd0)
      $display("FAIL midrst_hold: got req %b be %h addr %h rv %b%b streak %0d required 0", mem_req_o, mem_be_o, mem_addr_o, d_rvalid_o, if_rvalid_o, dut.streak);
    else passes++;
    step();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (d_rvalid_o !== 1'b0 || if_rvalid_o !== 1'b0 || dut.resp_owner !== OWN_NONE)
      $display("FAIL midrst_after: got rv %b%b owner %0d required 0 0 NONE", d_rvalid_o, if_rvalid_o, dut.resp_owner);
    else passes++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0]           = 32'h00500093;
    mem[1]           = 32'h00100113;
    mem[2]           = 32'h002081B3;
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    mem[32'h200 >> 2] = 32'h11223344;
    mem_rdata_i = '0;
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_collision();
    test_starvation();
    test_store();
    test_reset_mid_flight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
